// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types and helpers for the keypad scanner.
//   KEY_STAR / KEY_HASH : codes reported for the '*' and '#' keys
//   res_kind_e / scan_res_t : result of one full four-column scan
//   state_e             : press-tracking state machine states
//   key_map()           : (row, column) -> 4-bit key code
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } res_kind_e;

    // code is forced to zero for NONE/MULTI so whole-struct compares are exact
    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } scan_res_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } state_e;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = KEY_STAR;
            4'hD:    k = 4'h0;
            4'hE:    k = KEY_HASH;
            4'hF:    k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the key/digit outputs.
//   row      : keypad rows, active-low (driven by the keypad)
//   col      : keypad columns, active-low, one-cold
//   key_code / key_valid / key_held : accepted key reporting
//   units..thousands : BCD entry digits for the display driver
// master = scanner side, slave = keypad/display side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;

    modport master (
        input  row,
        output col, key_code, key_valid, key_held,
        output units, tens, hundreds, thousands
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, key_held,
        input  units, tens, hundreds, thousands
    );
endinterface

// File: rtl/keypad_scanner_digit_entry_reg.sv
// digit_entry_reg: four BCD entry digits updated by accepted key codes.
//   clk, rst_n : clock, async active-low reset
//   load_i     : one-cycle strobe, apply code_i
//   code_i     : key code (0-9 shift in, '*' clear, '#' backspace, A-D no-op)
//   units_o..thousands_o : registered digits
module digit_entry_reg
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] code_i,
    output logic [3:0] units_o,
    output logic [3:0] tens_o,
    output logic [3:0] hundreds_o,
    output logic [3:0] thousands_o
);

    logic [3:0] un_q, un_d, te_q, te_d, hu_q, hu_d, th_q, th_d;

    // entry rule: next digit values for the loaded code
    always_comb begin
        un_d = un_q;
        te_d = te_q;
        hu_d = hu_q;
        th_d = th_q;
        if (load_i) begin
            if (code_i <= 4'd9) begin
                th_d = hu_q;
                hu_d = te_q;
                te_d = un_q;
                un_d = code_i;
            end else if (code_i == KEY_STAR) begin
                th_d = 4'd0;
                hu_d = 4'd0;
                te_d = 4'd0;
                un_d = 4'd0;
            end else if (code_i == KEY_HASH) begin
                un_d = te_q;
                te_d = hu_q;
                hu_d = th_q;
                th_d = 4'd0;
            end else begin
                un_d = un_q;
            end
        end else begin
            un_d = un_q;
        end
    end

    // digit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            un_q <= 4'd0;
            te_q <= 4'd0;
            hu_q <= 4'd0;
            th_q <= 4'd0;
        end else begin
            un_q <= un_d;
            te_q <= te_d;
            hu_q <= hu_d;
            th_q <= th_d;
        end
    end

    assign units_o     = un_q;
    assign tens_o      = te_q;
    assign hundreds_o  = hu_q;
    assign thousands_o = th_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with scan-level debounce.
//   clk, rst_n : clock, async active-low reset
//   bus        : keypad_scanner_if.master (row in; col, key report, digits out)
// Params: SCAN_DIV cycles per column slot (>=2), DEBOUNCE_SCANS identical
// consecutive scans needed to accept a press or a release (>=1).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  bus
);

    localparam int             DW       = $clog2(SCAN_DIV);
    localparam int             CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_SCANS);

    logic [3:0]    row_meta_q, row_sync_q;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    hits_q, hits_d, hits_s;
    logic [3:0]    code_acc_q, code_acc_d, code_s;
    scan_res_t     res_s, last_res_q, last_res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    state_e        state_q, state_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          load_s, stable_s;

    // closures seen so far this scan, including the current column's rows;
    // column 0 starts a fresh accumulation, hit count saturates at 2
    always_comb begin
        hits_s = (idx_q == 2'd0) ? 2'd0 : hits_q;
        code_s = (idx_q == 2'd0) ? 4'd0 : code_acc_q;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                if (hits_s != 2'd2) begin
                    hits_s = hits_s + 2'd1;
                end else begin
                    hits_s = hits_s;
                end
                code_s = key_map(2'(r), idx_q);
            end else begin
                code_s = code_s;
            end
        end
        case (hits_s)
            2'd0:    res_s = '{kind: NONE,  code: 4'h0};
            2'd1:    res_s = '{kind: KEY,   code: code_s};
            default: res_s = '{kind: MULTI, code: 4'h0};
        endcase
    end

    // column divider, accumulation and scan-end debounce counter
    always_comb begin
        div_d      = div_q;
        idx_d      = idx_q;
        col_d      = col_q;
        hits_d     = hits_q;
        code_acc_d = code_acc_q;
        last_res_d = last_res_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d      = '0;
            idx_d      = idx_q + 2'd1;
            col_d      = ~(4'b0001 << idx_d);
            hits_d     = hits_s;
            code_acc_d = code_s;
            if (idx_q == 2'd3) begin
                done_d     = 1'b1;
                last_res_d = res_s;
                if (res_s != last_res_q) begin
                    cnt_d = CW'(1);
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                done_d = 1'b0;
            end
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // done_q marks the cycle where last_res_q/cnt_q hold a fresh scan result
    assign stable_s = done_q && (cnt_q == CNT_MAX);

    // press/release FSM: one report per press, no rollover while pressed
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        load_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable_s && (last_res_q.kind == KEY)) begin
                    state_d     = PRESSED;
                    key_code_d  = last_res_q.code;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    load_s      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESSED: begin
                if (stable_s && (last_res_q.kind == NONE)) begin
                    state_d    = IDLE;
                    key_held_d = 1'b0;
                end else begin
                    state_d = PRESSED;
                end
            end
            default: begin
                state_d    = IDLE;
                key_held_d = 1'b0;
            end
        endcase
    end

    // synchronizer, scan and FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            div_q       <= '0;
            idx_q       <= 2'd0;
            col_q       <= 4'b1110;
            hits_q      <= 2'd0;
            code_acc_q  <= 4'd0;
            last_res_q  <= '{kind: NONE, code: 4'h0};
            cnt_q       <= '0;
            done_q      <= 1'b0;
            state_q     <= IDLE;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= bus.row;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            hits_q      <= hits_d;
            code_acc_q  <= code_acc_d;
            last_res_q  <= last_res_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    digit_entry_reg u_digits (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_s),
        .code_i      (last_res_q.code),
        .units_o     (bus.units),
        .tens_o      (bus.tens),
        .hundreds_o  (bus.hundreds),
        .thousands_o (bus.thousands)
    );

    assign bus.col       = col_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (one full scan = 16 cycles). A keypad model pulls a row low while its
// column is driven low and the modelled key is closed.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 2;
    localparam int SCAN = 4 * SD;

    // key positions, index = row*4 + column
    localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5;
    localparam int K7 = 8, K9 = 10, KSTAR = 12, KHASH = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  row_s;
    int          checks = 0;
    int          fails = 0;

    keypad_scanner_if bus ();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_s = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !bus.col[c]) row_s[r] = 1'b0;
    end
    assign bus.row = row_s;

    function automatic logic [15:0] km(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    // observe n negedges: count key_valid pulses, last code, first pulse index
    task automatic watch(input int n, output int pulses, output logic [3:0] code, output int first_at);
        pulses = 0; code = 4'h0; first_at = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.key_valid === 1'b1) begin
                pulses++;
                code = bus.key_code;
                if (first_at < 0) first_at = i;
            end
        end
    endtask

    // press key k for hold_scans scans, then release for 4 scans
    task automatic tap(input int k, input int hold_scans, output int pulses, output logic [3:0] code);
        int p1, p2, f1, f2;
        logic [3:0] c1, c2;
        keys = km(k);
        watch(hold_scans * SCAN, p1, c1, f1);
        keys = 16'h0000;
        watch(4 * SCAN, p2, c2, f2);
        pulses = p1 + p2;
        code = c1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        repeat (3) @(negedge clk);
        checks++; if (bus.col !== 4'b1110) begin fails++; $display("FAIL reset_col got %b want 1110", bus.col); end
        checks++; if ({bus.key_code, bus.key_valid, bus.key_held} !== 6'b0) begin fails++;
            $display("FAIL reset_key got code=%h valid=%b held=%b want 0", bus.key_code, bus.key_valid, bus.key_held); end
        checks++; if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h0000) begin fails++;
            $display("FAIL reset_digits got %h want 0000", {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / SD) % 4));
            checks++; if (bus.col !== exp_col) begin fails++; $display("FAIL scan_col k=%0d got %b want %b", k, bus.col, exp_col); end
        end
        repeat (6) @(negedge clk);
        checks++; if (bus.col !== 4'b1101) begin fails++; $display("FAIL premid_col got %b want 1101", bus.col); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.col !== 4'b1110) begin fails++; $display("FAIL async_reset_col got %b want 1110", bus.col); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_press;
        int p, f, n;
        logic [3:0] c;
        keys = km(K5);
        watch(10 * SCAN, p, c, f);
        checks++; if (p !== 1) begin fails++; $display("FAIL press5_pulses got %0d want 1", p); end
        checks++; if (c !== 4'h5) begin fails++; $display("FAIL press5_code got %h want 5", c); end
        checks++; if (!((f + 1) >= (DS - 1) * SCAN && (f + 1) <= (DS + 1) * SCAN + 3)) begin fails++;
            $display("FAIL press5_latency got %0d want 16..51", f + 1); end
        checks++; if (bus.key_held !== 1'b1) begin fails++; $display("FAIL press5_held got %b want 1", bus.key_held); end
        checks++; if (bus.units !== 4'h5) begin fails++; $display("FAIL press5_units got %h want 5", bus.units); end
        keys = 16'h0000;
        n = 0; p = 0;
        while (bus.key_held === 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
            if (bus.key_valid === 1'b1) p++;
        end
        checks++; if (bus.key_held !== 1'b0) begin fails++; $display("FAIL release5_held got %b want 0", bus.key_held); end
        checks++; if (!(n >= (DS - 1) * SCAN && n <= (DS + 1) * SCAN + 3)) begin fails++;
            $display("FAIL release5_latency got %0d want 16..51", n); end
        checks++; if (p !== 0) begin fails++; $display("FAIL release5_pulses got %0d want 0", p); end
        watch(2 * SCAN, p, c, f);
    endtask

    task automatic test_entry;
        int seq_k[5] = '{K1, K2, K3, K4, K7};
        logic [3:0] seq_c[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7};
        int p;
        logic [3:0] c;
        for (int i = 0; i < 5; i++) begin
            tap(seq_k[i], 4, p, c);
            checks++; if (p !== 1 || c !== seq_c[i]) begin fails++;
                $display("FAIL entry_key%0d got pulses=%0d code=%h want 1/%h", i, p, c, seq_c[i]); end
        end
        checks++; if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h2347) begin fails++;
            $display("FAIL entry_digits got %h want 2347", {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
        tap(KHASH, 4, p, c);
        checks++; if (p !== 1 || c !== 4'hF) begin fails++; $display("FAIL hash_key got pulses=%0d code=%h want 1/f", p, c); end
        checks++; if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h0234) begin fails++;
            $display("FAIL hash_digits got %h want 0234", {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
        tap(KSTAR, 4, p, c);
        checks++; if (p !== 1 || c !== 4'hE) begin fails++; $display("FAIL star_key got pulses=%0d code=%h want 1/e", p, c); end
        checks++; if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h0000) begin fails++;
            $display("FAIL star_digits got %h want 0000", {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
    endtask

    task automatic test_bounce;
        logic [3:0] prev, c;
        logic found;
        int p1, p2, p3, f;
        found = 1'b0;
        prev = bus.col;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && bus.col == 4'b1110) found = 1'b1;
            prev = bus.col;
        end
        checks++; if (found !== 1'b1) begin fails++; $display("FAIL bounce_align got %b want 1", found); end
        p1 = 0;
        for (int i = 0; i < 3 * SCAN; i++) begin
            keys = (((i / 3) % 2) == 0) ? km(K9) : 16'h0000;
            @(negedge clk);
            if (bus.key_valid === 1'b1) p1++;
        end
        keys = km(K9);
        watch(6 * SCAN, p2, c, f);
        keys = 16'h0000;
        watch(4 * SCAN, p3, c, f);
        checks++; if (p1 !== 0) begin fails++; $display("FAIL bounce_early got %0d pulses want 0", p1); end
        checks++; if (p2 !== 1) begin fails++; $display("FAIL bounce_hold got %0d pulses want 1", p2); end
        checks++; if (p3 !== 0) begin fails++; $display("FAIL bounce_release got %0d pulses want 0", p3); end
        checks++; if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h0009) begin fails++;
            $display("FAIL bounce_digits got %h want 0009", {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
    endtask

    task automatic test_ghost;
        int p, f;
        logic [3:0] c;
        keys = km(K1) | km(K5);
        watch(6 * SCAN, p, c, f);
        checks++; if (p !== 0 || bus.key_held !== 1'b0) begin fails++;
            $display("FAIL ghost_multi got pulses=%0d held=%b want 0/0", p, bus.key_held); end
        keys = 16'h0000;
        watch(4 * SCAN, p, c, f);
        keys = km(K2);
        watch(4 * SCAN, p, c, f);
        checks++; if (p !== 1 || c !== 4'h2) begin fails++; $display("FAIL roll_first got pulses=%0d code=%h want 1/2", p, c); end
        keys = km(K2) | km(K3);
        watch(4 * SCAN, p, c, f);
        checks++; if (p !== 0 || bus.key_held !== 1'b1) begin fails++;
            $display("FAIL roll_both got pulses=%0d held=%b want 0/1", p, bus.key_held); end
        keys = km(K2);
        watch(4 * SCAN, p, c, f);
        checks++; if (p !== 0) begin fails++; $display("FAIL roll_back got pulses=%0d want 0", p); end
        keys = 16'h0000;
        watch(4 * SCAN, p, c, f);
        checks++; if (p !== 0 || bus.key_held !== 1'b0) begin fails++;
            $display("FAIL roll_release got pulses=%0d held=%b want 0/0", p, bus.key_held); end
        checks++; if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h0092) begin fails++;
            $display("FAIL roll_digits got %h want 0092", {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
    endtask

    task automatic test_non_digit;
        int p;
        logic [3:0] c;
        tap(KA, 4, p, c);
        checks++; if (p !== 1 || c !== 4'hA) begin fails++; $display("FAIL keyA got pulses=%0d code=%h want 1/a", p, c); end
        checks++; if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h0092) begin fails++;
            $display("FAIL keyA_digits got %h want 0092", {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
    endtask

    task automatic test_reset_mid_press;
        int p, f;
        logic [3:0] c;
        keys = km(K5);
        watch(4 * SCAN, p, c, f);
        checks++; if (bus.key_held !== 1'b1 || {bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h0925) begin fails++;
            $display("FAIL midpress_pre got held=%b digits=%h want 1/0925", bus.key_held,
                     {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.key_code, bus.key_valid, bus.key_held} !== 6'b0 || bus.col !== 4'b1110) begin fails++;
            $display("FAIL midpress_reset got code=%h valid=%b held=%b col=%b want 0/0/0/1110",
                     bus.key_code, bus.key_valid, bus.key_held, bus.col); end
        checks++; if ({bus.thousands, bus.hundreds, bus.tens, bus.units} !== 16'h0000) begin fails++;
            $display("FAIL midpress_digits got %h want 0000", {bus.thousands, bus.hundreds, bus.tens, bus.units}); end
        keys = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        watch(4 * SCAN, p, c, f);
        checks++; if (p !== 0) begin fails++; $display("FAIL after_reset_pulses got %0d want 0", p); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_entry();
        test_bounce();
        test_ghost();
        test_non_digit();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side companion to the multiplexed seven-segment display driver. It time-multiplexes the columns of a 4x4 matrix keypad and reads back the row lines. Row samples are debounced over whole scans, and each new key press is reported once as a 4-bit code. Decimal keys are also accumulated into four BCD digit registers (units…thousands), which connect directly to the display driver's digit inputs.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven (0.5 ms at 100 MHz); minimum 2.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-scan results required to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- row  in  4  keypad rows, active-low with pull-ups, asynchronous to clk.
- col  out  4  keypad columns, active-low; exactly one bit low at all times.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-cycle pulse when a new press is accepted.
- key_held  out  1  high while an accepted key is held.
- units, tens, hundreds, thousands  out  4 each  BCD entry digits.

## Operation
- Row synchronizer: row passes through two flops, reset value 4'b1111.
- Column scan:
  - A column index (0–3) advances every SCAN_DIV cycles and wraps 3→0.
  - col = ~(1 << index).
  - The synchronized row is sampled on the last cycle of each column slot, after settling.
- Key map, key = (row r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
  - Codes: digits give their value; A–D give 4'hA–4'hD; * gives 4'hE; # gives 4'hF.
- Scan result: evaluated at the column-3 sample.
  - NONE: no closures across all four columns.
  - KEY(code): exactly one closure.
  - MULTI: two or more closures (ghosting rejection).
- Debounce:
  - A counter tracks how many consecutive scan results equal the previous one.
  - A result is "stable" when the counter reaches DEBOUNCE_SCANS.
  - The counter saturates at DEBOUNCE_SCANS.
  - Any change in the result resets the counter to 1.
- State machine (IDLE, PRESSED):
  - IDLE → PRESSED on a stable KEY(code). Actions: key_code ← code; key_valid pulse; key_held ← 1; apply the entry rule below.
  - PRESSED → IDLE on a stable NONE. Action: key_held ← 0.
  - In PRESSED, a stable MULTI or a different stable KEY is ignored (no rollover); only a stable NONE releases.
  - In IDLE, a stable MULTI or a stable NONE is ignored.
  - Exactly one key_valid pulse is generated per press-release cycle.
- Entry rule, applied on the key_valid cycle:
  - Code 0–9: thousands ← hundreds, hundreds ← tens, tens ← units, units ← code. The old thousands digit is discarded.
  - 4'hE (*): all four digits ← 0.
  - 4'hF (#): backspace. units ← tens, tens ← hundreds, hundreds ← thousands, thousands ← 0.
  - 4'hA–4'hD: digits unchanged; the code is still reported.

## Timing
- Reset values:
  - col = 4'b1110
  - key_code = 0, key_valid = 0, key_held = 0
  - all digits = 0
  - state IDLE; scan index, divider and debounce counter all 0
  - last scan result = NONE
- Reset asserted mid-scan or mid-press returns to these values immediately, without waiting for a clock edge. After release, scanning restarts at column 0.
- Outputs are registered:
  - key_valid, key_code, key_held and the digits change on the cycle after the scan-end sample that makes the result stable.
- Press latency, measured from the row lines becoming steady:
  - At least (DEBOUNCE_SCANS−1)·4·SCAN_DIV cycles.
  - At most (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 3 cycles.
- Release latency has the same bounds.
- Bounce shorter than one column slot between samples is invisible; bounce across samples only delays acceptance.
- The divider counts 0…SCAN_DIV−1; its width is $clog2(SCAN_DIV).

## Structure
- Package keypad_pkg:
  - key code constants: KEY_STAR = 4'hE, KEY_HASH = 4'hF
  - scan-result encoding: 2-bit kind {NONE, KEY, MULTI} plus a 4-bit code
  - state enum {IDLE, PRESSED}
  - row/column-to-code map function
- Sub-module digit_entry_reg: the four BCD registers. Inputs are clk, rst_n, a load strobe and the code; it applies the entry rule.
- The top level holds the synchronizer, the scan divider, the debounce logic and the FSM.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2. The keypad model pulls a row low whenever its column is low and the modelled key is closed.
- Reset: assert rst_n=0 mid-scan → col=4'b1110, all outputs 0, asynchronously; after release, col cycles 1110→1101→1011→0111 every 4 cycles.
- Single press: hold key "5" (r1, c1) for 10 scans → exactly one key_valid pulse with key_code=5; key_held=1 until 2 stable NONE scans after release; units=5.
- Entry: press and release 1, 2, 3, 4, 7 in sequence → thousands..units = 2,3,4,7. Then # → 0,2,3,4. Then * → 0,0,0,0.
- Bounce: toggle the "9" contact every 3 cycles for 3 scans, then hold → one key_valid pulse only, issued after a steady state is reached.
- Ghost/rollover: hold "1" and "5" together from IDLE → no pulse. Then hold "2", and press "3" while "2" is held → one pulse (code 2) only; no new pulse until full release.
- Non-digit key: press "A" → key_valid with key_code=4'hA; digits unchanged.
